// File: rtl/vga_timing_gen.sv
// Runtime-programmable raster timing generator: shadow/active timing registers swapped at
// frame end, HS/VS/DE with polarity, pixel coordinates and strobes behind a PIPE_DLY delay line.
module vga_timing_gen #(
   parameter int CNT_W        = 12,
   parameter int PIPE_DLY     = 2,
   parameter int H_TOTAL_INIT = 799,
   parameter int H_SYNC_INIT  = 95,
   parameter int H_START_INIT = 143,
   parameter int H_END_INIT   = 783,
   parameter int V_TOTAL_INIT = 524,
   parameter int V_SYNC_INIT  = 1,
   parameter int V_START_INIT = 35,
   parameter int V_END_INIT   = 515
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_addr,
   input  logic [CNT_W-1:0] cfg_wdata,
   input  logic             cfg_commit,
   output logic             cfg_pending,
   output logic             hs,
   output logic             vs,
   output logic             de,
   output logic [CNT_W-1:0] px_x,
   output logic [CNT_W-1:0] px_y,
   output logic             frame_start,
   output logic             line_start
);

   localparam int NF     = 8;
   localparam int PW     = 5 + 2 * CNT_W;
   localparam int F_HTOT = 0;
   localparam int F_HSYN = 1;
   localparam int F_HSTA = 2;
   localparam int F_HEND = 3;
   localparam int F_VTOT = 4;
   localparam int F_VSYN = 5;
   localparam int F_VSTA = 6;
   localparam int F_VEND = 7;

   function automatic logic [CNT_W-1:0] init_val(input int idx);
      case (idx)
         F_HTOT:  return CNT_W'(H_TOTAL_INIT);
         F_HSYN:  return CNT_W'(H_SYNC_INIT);
         F_HSTA:  return CNT_W'(H_START_INIT);
         F_HEND:  return CNT_W'(H_END_INIT);
         F_VTOT:  return CNT_W'(V_TOTAL_INIT);
         F_VSYN:  return CNT_W'(V_SYNC_INIT);
         F_VSTA:  return CNT_W'(V_START_INIT);
         F_VEND:  return CNT_W'(V_END_INIT);
         default: return '0;
      endcase
   endfunction

   logic [CNT_W-1:0] act_q [NF];
   logic [CNT_W-1:0] act_d [NF];
   logic [CNT_W-1:0] shd_q [NF];
   logic [CNT_W-1:0] shd_d [NF];
   logic [1:0]       pol_q, pol_d, shpol_q, shpol_d;
   logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic             pend_q, pend_d;
   logic [PW-1:0]    pipe_q [PIPE_DLY+1];
   logic [PW-1:0]    pipe_d [PIPE_DLY+1];

   logic             h_wrap, v_wrap, frame_end, xfer;
   logic             h_act, v_act, de_raw, hs_raw, vs_raw, h_zero;
   logic [CNT_W-1:0] x_raw, y_raw;

   always_comb begin
      h_wrap    = (h_cnt_q >= act_q[F_HTOT]);
      v_wrap    = (v_cnt_q >= act_q[F_VTOT]);
      frame_end = en & h_wrap & v_wrap;
      xfer      = frame_end & (pend_q | cfg_commit);

      h_cnt_d = '0;
      v_cnt_d = '0;
      if (en) begin
         h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
         v_cnt_d = v_cnt_q;
         if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
         end
      end

      pend_d = xfer ? 1'b0 : (pend_q | cfg_commit);

      // Transfer uses the shadow as it was before this cycle's write.
      act_d = act_q;
      pol_d = pol_q;
      if (xfer) begin
         act_d = shd_q;
         pol_d = shpol_q;
      end

      shd_d   = shd_q;
      shpol_d = shpol_q;
      if (cfg_we) begin
         if (!cfg_addr[3]) begin
            shd_d[cfg_addr[2:0]] = cfg_wdata;
         end else if (cfg_addr == 4'd8) begin
            shpol_d = cfg_wdata[1:0];
         end
      end
   end

   always_comb begin
      h_act  = (h_cnt_q >= act_q[F_HSTA]) && (h_cnt_q < act_q[F_HEND]);
      v_act  = (v_cnt_q >= act_q[F_VSTA]) && (v_cnt_q < act_q[F_VEND]);
      de_raw = en & h_act & v_act;
      hs_raw = en & (h_cnt_q <= act_q[F_HSYN]);
      vs_raw = en & (v_cnt_q <= act_q[F_VSYN]);
      h_zero = (h_cnt_q == '0);
      x_raw  = de_raw ? h_cnt_q - act_q[F_HSTA] : '0;
      y_raw  = de_raw ? v_cnt_q - act_q[F_VSTA] : '0;
   end

   // With en low the stage input is the inactive level, so the pipe drains to it.
   assign pipe_d[0] = {hs_raw ^ pol_q[0], vs_raw ^ pol_q[1], de_raw,
                       en & h_zero & (v_cnt_q == '0), en & h_zero, x_raw, y_raw};

   genvar gi;
   generate
      for (gi = 1; gi <= PIPE_DLY; gi++) begin : g_pipe
         assign pipe_d[gi] = pipe_q[gi-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NF; i++) begin
            act_q[i] <= init_val(i);
            shd_q[i] <= init_val(i);
         end
         pol_q   <= '0;
         shpol_q <= '0;
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         pend_q  <= 1'b0;
         for (int i = 0; i <= PIPE_DLY; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         act_q   <= act_d;
         shd_q   <= shd_d;
         pol_q   <= pol_d;
         shpol_q <= shpol_d;
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         pend_q  <= pend_d;
         pipe_q  <= pipe_d;
      end
   end

   assign {hs, vs, de, frame_start, line_start, px_x, px_y} = pipe_q[PIPE_DLY];
   assign cfg_pending = pend_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: directed mode switches plus random config/enable/reset traffic,
// checked every cycle against a frame-time (cycles since frame start) reference model.
module tb_vga_timing_gen;

   localparam int CNT_W    = 12;
   localparam int PIPE_DLY = 2;
   localparam int HT = 39, HSY = 4, HST = 8, HE = 36;
   localparam int VT = 19, VSY = 1, VST = 3, VE = 17;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic             en = 1'b0;
   logic             cfg_we = 1'b0;
   logic [3:0]       cfg_addr = '0;
   logic [CNT_W-1:0] cfg_wdata = '0;
   logic             cfg_commit = 1'b0;
   logic             cfg_pending, hs, vs, de, frame_start, line_start;
   logic [CNT_W-1:0] px_x, px_y;

   vga_timing_gen #(
      .CNT_W(CNT_W), .PIPE_DLY(PIPE_DLY),
      .H_TOTAL_INIT(HT), .H_SYNC_INIT(HSY), .H_START_INIT(HST), .H_END_INIT(HE),
      .V_TOTAL_INIT(VT), .V_SYNC_INIT(VSY), .V_START_INIT(VST), .V_END_INIT(VE)
   ) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
      .hs(hs), .vs(vs), .de(de), .px_x(px_x), .px_y(px_y),
      .frame_start(frame_start), .line_start(line_start)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             hs, vs, de, fs, ls;
      logic [CNT_W-1:0] x, y;
   } exp_t;

   exp_t exp_q[$];
   int   m_act[9];
   int   m_sh[9];
   bit   m_pend;
   int   m_t;
   int   checks = 0;
   int   failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_act  = '{HT, HSY, HST, HE, VT, VSY, VST, VE, 0};
      m_sh   = m_act;
      m_pend = 1'b0;
      m_t    = 0;
      exp_q.delete();
      for (int i = 0; i <= PIPE_DLY; i++) exp_q.push_back('0);
   endfunction

   function automatic int frame_len();
      return (m_act[0] + 1) * (m_act[4] + 1);
   endfunction

   function automatic bit frame_end_next();
      return en && (m_t == frame_len() - 1);
   endfunction

   // Advance the model by one clock edge using the inputs about to be sampled.
   function automatic void model_adv();
      exp_t e;
      int   h, v;
      bit   fe, xfer, hp, vp;
      hp = m_act[8][0];
      vp = m_act[8][1];
      e = '0;
      e.hs = hp;
      e.vs = vp;
      fe = 1'b0;
      if (en) begin
         h = m_t % (m_act[0] + 1);
         v = m_t / (m_act[0] + 1);
         e.hs = (h <= m_act[1]) ^ hp;
         e.vs = (v <= m_act[5]) ^ vp;
         e.de = (h >= m_act[2]) && (h < m_act[3]) && (v >= m_act[6]) && (v < m_act[7]);
         if (e.de) begin
            e.x = CNT_W'(h - m_act[2]);
            e.y = CNT_W'(v - m_act[6]);
         end
         e.ls = (h == 0);
         e.fs = (m_t == 0);
         fe = (m_t == frame_len() - 1);
      end
      exp_q.push_back(e);
      void'(exp_q.pop_front());
      xfer = fe && (m_pend || cfg_commit);
      if (xfer) m_act = m_sh;
      m_pend = xfer ? 1'b0 : (m_pend || cfg_commit);
      if (cfg_we && cfg_addr <= 4'd8)
         m_sh[cfg_addr] = (cfg_addr == 4'd8) ? int'(cfg_wdata[1:0]) : int'(cfg_wdata);
      m_t = (!en || fe) ? 0 : m_t + 1;
   endfunction

   task automatic compare_all();
      exp_t e;
      e = exp_q[0];
      check("hs", 32'(hs), 32'(e.hs));
      check("vs", 32'(vs), 32'(e.vs));
      check("de", 32'(de), 32'(e.de));
      check("frame_start", 32'(frame_start), 32'(e.fs));
      check("line_start", 32'(line_start), 32'(e.ls));
      check("px_x", 32'(px_x), 32'(e.x));
      check("px_y", 32'(px_y), 32'(e.y));
      check("cfg_pending", 32'(cfg_pending), 32'(m_pend));
   endtask

   // Called at a negedge with inputs set; returns at the next negedge.
   task automatic tick();
      if (reset_n) model_adv();
      @(posedge clk);
      @(negedge clk);
      cfg_we     = 1'b0;
      cfg_commit = 1'b0;
      compare_all();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic wr(input logic [3:0] a, input logic [CNT_W-1:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      tick();
   endtask

   task automatic commit();
      cfg_commit = 1'b1;
      tick();
   endtask

   task automatic wait_frame_end();
      int k;
      k = 0;
      while (!frame_end_next() && k < 5000) begin
         tick();
         k++;
      end
      check("frame_end_bound", 32'(frame_end_next()), 32'd1);
   endtask

   task automatic areset();
      #2 reset_n = 1'b0;
      #1 model_reset();
      compare_all();
      @(posedge clk);
      @(negedge clk);
      compare_all();
      reset_n = 1'b1;
   endtask

   initial begin
      logic [3:0]       a;
      logic [CNT_W-1:0] d;
      int               ncyc;
      #2 reset_n = 1'b0;
      model_reset();
      @(negedge clk);
      compare_all();
      reset_n = 1'b1;
      run(3);

      $display("phase: init timing");
      en = 1'b1;
      run(2 * (HT + 1) * (VT + 1) + 50);

      $display("phase: program 9/1/3/7/5/0/1/4 and commit");
      wr(4'd0, 12'd9); wr(4'd1, 12'd1); wr(4'd2, 12'd3); wr(4'd3, 12'd7);
      wr(4'd4, 12'd5); wr(4'd5, 12'd0); wr(4'd6, 12'd1); wr(4'd7, 12'd4);
      commit();
      wait_frame_end();
      run(130);

      $display("phase: polarity 2'b11");
      wr(4'd8, 12'd3);
      commit();
      run(130);

      $display("phase: commit in frame-end cycle");
      wr(4'd0, 12'd11);
      wait_frame_end();
      commit();
      run(150);

      $display("phase: write in transfer cycle");
      wr(4'd0, 12'd13);
      commit();
      wait_frame_end();
      wr(4'd0, 12'd7);
      run(100);
      commit();
      run(200);

      $display("phase: en drop then async reset");
      run(5);
      en = 1'b0;
      run(8);
      en = 1'b1;
      run(47);
      areset();
      run(30);

      $display("phase: random");
      for (int c = 0; c < 12000; c++) begin
         if ($urandom_range(0, 3999) == 0) begin
            areset();
         end else begin
            if (en && $urandom_range(0, 199) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
               a = 4'($urandom_range(0, 15));
               case (a)
                  4'd0:    d = CNT_W'($urandom_range(3, 15));
                  4'd4:    d = CNT_W'($urandom_range(2, 9));
                  4'd8:    d = CNT_W'($urandom_range(0, 3));
                  default: d = (a > 4'd8) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 17));
               endcase
               cfg_we    = 1'b1;
               cfg_addr  = a;
               cfg_wdata = d;
            end
            if ($urandom_range(0, 39) == 0) cfg_commit = 1'b1;
            ncyc = c;
            tick();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
